// File: rtl/motion_pkg.sv
// motion_pkg: definitions shared by the motion-detect datapath blocks.
//   mask_mode_t                  output mode of the foreground mask generator
//   MOTION_DEFAULT_FRAME_PIXELS  pixels per frame (720x540)
//   MOTION_DEFAULT_THRESHOLD     foreground threshold used after reset
//   decode_mode()                maps the raw 2-bit mode input onto mask_mode_t
package motion_pkg;

  typedef enum logic [1:0] {
    MODE_MASK   = 2'b00,
    MODE_DIFF   = 2'b01,
    MODE_MASKED = 2'b10
  } mask_mode_t;

  localparam int MOTION_DEFAULT_FRAME_PIXELS = 388800;
  localparam int MOTION_DEFAULT_THRESHOLD    = 50;

  // The unused encoding 2'b11 falls back to the plain mask.
  function automatic mask_mode_t decode_mode(input logic [1:0] raw);
    mask_mode_t m;
    case (raw)
      2'b01:   m = MODE_DIFF;
      2'b10:   m = MODE_MASKED;
      default: m = MODE_MASK;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/motion_mask_pipe.sv
// motion_mask_pipe: two-stage pipelined foreground mask generator.
// Pops one base and one live pixel per cycle from two FWFT FIFOs, thresholds
// |live - base| and pushes one output pixel per cycle downstream. Threshold
// and mode are latched when the first pixel of a frame enters stage 2, so
// they stay constant within a frame. A per-frame foreground count is
// published together with a one-cycle frame_done pulse.
//
// Ports:
//   clock, reset          clock; asynchronous active-low reset
//   base_rd_en/empty/dout base-image FWFT FIFO read side
//   img_in_rd_en/empty/dout live-image FWFT FIFO read side
//   mask_out_wr_en/full/din output FIFO write side
//   threshold, threshold_load  pending threshold and its capture strobe
//   mode                  00 MASK, 01 DIFF, 10 MASKED, 11 as MASK
//   frame_done            pulses the cycle after a frame's last pixel is written
//   fg_count              foreground pixels of the last completed frame
//
// Handshake: a stage moves its word forward only when it is valid and the
// next stage is ready; a stage is ready when it is empty or its own word
// leaves in the same cycle. A stalled stage holds its contents unchanged.
module motion_mask_pipe
  import motion_pkg::*;
#(
  parameter int PIXEL_WIDTH       = 8,
  parameter int FRAME_PIXELS      = MOTION_DEFAULT_FRAME_PIXELS,
  parameter int DEFAULT_THRESHOLD = MOTION_DEFAULT_THRESHOLD,
  localparam int CNT_W            = $clog2(FRAME_PIXELS + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   base_rd_en,
  input  logic                   base_empty,
  input  logic [PIXEL_WIDTH-1:0] base_dout,
  output logic                   img_in_rd_en,
  input  logic                   img_in_empty,
  input  logic [PIXEL_WIDTH-1:0] img_in_dout,
  output logic                   mask_out_wr_en,
  input  logic                   mask_out_full,
  output logic [PIXEL_WIDTH-1:0] mask_out_din,
  input  logic [PIXEL_WIDTH-1:0] threshold,
  input  logic                   threshold_load,
  input  logic [1:0]             mode,
  output logic                   frame_done,
  output logic [CNT_W-1:0]       fg_count
);

  localparam logic [CNT_W-1:0]       LAST_IDX = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [PIXEL_WIDTH-1:0] THR_RST  = PIXEL_WIDTH'(DEFAULT_THRESHOLD);

  // Stage 1
  logic                   s1_valid_q;
  logic [PIXEL_WIDTH-1:0] s1_diff_q;
  logic [PIXEL_WIDTH-1:0] s1_pix_q;
  // Stage 2
  logic                   s2_valid_q;
  logic [PIXEL_WIDTH-1:0] s2_data_q;
  logic                   s2_fg_q;
  // Frame settings
  logic [PIXEL_WIDTH-1:0] thr_pend_q;
  logic [PIXEL_WIDTH-1:0] thr_act_q;
  mask_mode_t             mode_act_q;
  // Frame position of the next pixel entering stage 2, and write-side counters
  logic [CNT_W-1:0]       s2_idx_q;
  logic [CNT_W-1:0]       pix_cnt_q;
  logic [CNT_W-1:0]       fg_acc_q;
  logic [CNT_W-1:0]       fg_count_q;
  logic                   frame_done_q;

  logic                   s1_ready;
  logic                   s2_ready;
  logic                   rd;
  logic                   s1_adv;
  logic                   wr;
  logic                   last_wr;
  logic                   frame_start;
  logic [PIXEL_WIDTH-1:0] diff_d;
  logic [PIXEL_WIDTH-1:0] thr_use;
  mask_mode_t             mode_use;
  logic                   fg_d;
  logic [PIXEL_WIDTH-1:0] data_d;

  assign s2_ready = !s2_valid_q || !mask_out_full;
  assign s1_ready = !s1_valid_q || s2_ready;
  // Reset gates the reads so both pop strobes read 0 while reset is held.
  assign rd       = reset && !base_empty && !img_in_empty && s1_ready;
  assign s1_adv   = s1_valid_q && s2_ready;
  assign wr       = s2_valid_q && !mask_out_full;
  assign last_wr  = wr && (pix_cnt_q == LAST_IDX);

  assign diff_d = (img_in_dout > base_dout) ? (img_in_dout - base_dout)
                                            : (base_dout - img_in_dout);

  // The first pixel of a frame already uses the settings it latches.
  assign frame_start = (s2_idx_q == '0);

  always_comb begin
    thr_use  = thr_act_q;
    mode_use = mode_act_q;
    if (frame_start) begin
      thr_use  = thr_pend_q;
      mode_use = decode_mode(mode);
    end
  end

  always_comb begin
    fg_d   = (s1_diff_q > thr_use);
    data_d = '0;
    case (mode_use)
      MODE_DIFF:   data_d = s1_diff_q;
      MODE_MASKED: data_d = fg_d ? s1_pix_q : '0;
      default:     data_d = fg_d ? '1 : '0;
    endcase
  end

  // Stage 1
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      s1_pix_q   <= '0;
    end else if (s1_ready) begin
      s1_valid_q <= rd;
      if (rd) begin
        s1_diff_q <= diff_d;
        s1_pix_q  <= img_in_dout;
      end
    end
  end

  // Stage 2 and frame settings
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_fg_q    <= 1'b0;
      thr_act_q  <= THR_RST;
      mode_act_q <= MODE_MASK;
      s2_idx_q   <= '0;
    end else if (s2_ready) begin
      s2_valid_q <= s1_valid_q;
      if (s1_adv) begin
        s2_data_q <= data_d;
        s2_fg_q   <= fg_d;
        s2_idx_q  <= (s2_idx_q == LAST_IDX) ? '0 : s2_idx_q + 1'b1;
        if (frame_start) begin
          thr_act_q  <= thr_pend_q;
          mode_act_q <= decode_mode(mode);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      thr_pend_q <= THR_RST;
    end else if (threshold_load) begin
      thr_pend_q <= threshold;
    end
  end

  // Frame statistics, advanced on every downstream write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_cnt_q    <= '0;
      fg_acc_q     <= '0;
      fg_count_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_wr;
      if (last_wr) begin
        fg_count_q <= fg_acc_q + CNT_W'(s2_fg_q);
        pix_cnt_q  <= '0;
        fg_acc_q   <= '0;
      end else if (wr) begin
        pix_cnt_q <= pix_cnt_q + 1'b1;
        fg_acc_q  <= fg_acc_q + CNT_W'(s2_fg_q);
      end
    end
  end

  assign base_rd_en     = rd;
  assign img_in_rd_en   = rd;
  assign mask_out_wr_en = wr;
  assign mask_out_din   = s2_data_q;
  assign frame_done     = frame_done_q;
  assign fg_count       = fg_count_q;

endmodule

// File: tb/tb_motion_mask_pipe.sv
// tb_motion_mask_pipe: directed bench for motion_mask_pipe with a 16-pixel
// frame. A reference model computes each output word (and the frame count on
// a frame's last pixel) when the pixel is queued; the words are popped and
// compared as the DUT writes them.
module tb_motion_mask_pipe;

  localparam int PW = 8;
  localparam int FP = 16;
  localparam int CW = $clog2(FP + 1);
  localparam int EW = 1 + CW + PW;

  // Clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          base_rd_en, base_empty;
  logic [PW-1:0] base_dout;
  logic          img_in_rd_en, img_in_empty;
  logic [PW-1:0] img_in_dout;
  logic          mask_out_wr_en, mask_out_full;
  logic [PW-1:0] mask_out_din;
  logic [PW-1:0] threshold;
  logic          threshold_load;
  logic [1:0]    mode;
  logic          frame_done;
  logic [CW-1:0] fg_count;

  motion_mask_pipe #(
    .PIXEL_WIDTH      (PW),
    .FRAME_PIXELS     (FP),
    .DEFAULT_THRESHOLD(50)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .base_rd_en    (base_rd_en),
    .base_empty    (base_empty),
    .base_dout     (base_dout),
    .img_in_rd_en  (img_in_rd_en),
    .img_in_empty  (img_in_empty),
    .img_in_dout   (img_in_dout),
    .mask_out_wr_en(mask_out_wr_en),
    .mask_out_full (mask_out_full),
    .mask_out_din  (mask_out_din),
    .threshold     (threshold),
    .threshold_load(threshold_load),
    .mode          (mode),
    .frame_done    (frame_done),
    .fg_count      (fg_count)
  );

  // Scoreboard state
  int            total = 0;
  int            bad   = 0;
  logic [PW-1:0] base_q[$];
  logic [PW-1:0] img_q[$];
  logic [EW-1:0] exp_q[$];     // {last, frame count, data}
  int            cyc = 0;
  logic          last_rd = 1'b0;
  logic          last_wr = 1'b0;
  int            first_rd_cyc = -1;
  int            first_wr_cyc = -1;
  int            last_wr_cyc  = -1;
  logic          exp_done_next = 1'b0;
  logic [CW-1:0] exp_cnt_next  = '0;

  // Reference model state
  int            m_idx = 0;
  logic [CW-1:0] m_acc = '0;
  logic [PW-1:0] m_pend = 8'd50;
  logic [PW-1:0] m_thr  = 8'd50;
  logic [1:0]    m_mode = 2'b00;
  logic [1:0]    cur_mode = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    base_empty   = (base_q.size() == 0);
    img_in_empty = (img_q.size() == 0);
    base_dout    = base_empty ? '0 : base_q[0];
    img_in_dout  = img_in_empty ? '0 : img_q[0];
  endtask

  // Driver: queue one pixel pair and its expected output.
  task automatic push_px(input logic [PW-1:0] b, input logic [PW-1:0] i);
    logic [PW-1:0] d;
    logic [PW-1:0] o;
    logic          fg;
    logic          lst;
    d = (i > b) ? i - b : b - i;
    if (m_idx == 0) begin
      m_thr  = m_pend;
      m_mode = cur_mode;
    end
    fg = (d > m_thr);
    case (m_mode)
      2'b01:   o = d;
      2'b10:   o = fg ? i : 8'h00;
      default: o = fg ? 8'hFF : 8'h00;
    endcase
    m_acc = m_acc + CW'(fg);
    lst   = (m_idx == FP - 1);
    exp_q.push_back({lst, lst ? m_acc : {CW{1'b0}}, o});
    if (lst) m_acc = '0;
    m_idx = lst ? 0 : m_idx + 1;
    base_q.push_back(b);
    img_q.push_back(i);
    refresh();
  endtask

  // One clock: sample outputs on the falling edge, update FIFO heads after
  // the rising edge.
  task automatic step();
    logic [EW-1:0] e;
    logic          rd_now;
    @(negedge clock);
    cyc++;
    last_rd = base_rd_en;
    last_wr = mask_out_wr_en;
    check("rd_en_pair", img_in_rd_en, base_rd_en);
    if (base_empty || img_in_empty) check("rd_on_empty", base_rd_en, 0);
    if (mask_out_full) check("wr_while_full", mask_out_wr_en, 0);
    check("frame_done", frame_done, exp_done_next);
    if (frame_done === 1'b1) check("fg_count", fg_count, exp_cnt_next);
    exp_done_next = 1'b0;
    if (mask_out_wr_en === 1'b1) begin
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_write", mask_out_wr_en, 0);
      end else begin
        e = exp_q.pop_front();
        check("mask_out_din", mask_out_din, e[PW-1:0]);
        if (e[EW-1]) begin
          exp_done_next = 1'b1;
          exp_cnt_next  = e[PW +: CW];
        end
      end
    end
    if (base_rd_en === 1'b1 && first_rd_cyc < 0) first_rd_cyc = cyc;
    rd_now = (base_rd_en === 1'b1);
    @(posedge clock);
    #1;
    if (rd_now) begin
      if (base_q.size() > 0) void'(base_q.pop_front());
      if (img_q.size() > 0) void'(img_q.pop_front());
    end
    refresh();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      step();
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    step();
  endtask

  task automatic load_thr(input logic [PW-1:0] v);
    threshold      = v;
    threshold_load = 1'b1;
    step();
    threshold_load = 1'b0;
    m_pend         = v;
  endtask

  task automatic push_quiet();
    logic [PW-1:0] b;
    b = PW'($urandom_range(0, 200));
    push_px(b, b + PW'($urandom_range(0, 50)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int            rd_cnt;
    logic [PW-1:0] tmp;
    mask_out_full  = 1'b0;
    threshold      = '0;
    threshold_load = 1'b0;
    mode           = 2'b00;
    refresh();

    // Reset state, with pixels already waiting in the input FIFOs
    push_px(8'd100, 8'd150);
    push_px(8'd100, 8'd151);
    push_px(8'd100, 8'd49);
    push_px(8'd100, 8'd100);
    repeat (2) @(posedge clock);
    #1;
    check("rst_base_rd_en", base_rd_en, 0);
    check("rst_img_rd_en", img_in_rd_en, 0);
    check("rst_wr_en", mask_out_wr_en, 0);
    check("rst_din", mask_out_din, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_fg_count", fg_count, 0);
    reset = 1'b1;

    // Frame 0, pixels 0-3: MASK, threshold 50 -> 00 FF FF 00
    drain();
    check("latency", first_wr_cyc - first_rd_cyc, 2);
    check("one_per_cycle", last_wr_cyc - first_wr_cyc, 3);

    // Frame 0, pixels 4-15 with back-pressure; 5 foreground incl. the last
    for (int k = 4; k < FP - 1; k++) begin
      if (k == 8 || k == 12) push_px(8'd100, 8'd220);
      else push_px(8'd100, PW'($urandom_range(50, 150)));
    end
    push_px(8'd100, 8'd0);
    repeat (3) step();
    mask_out_full = 1'b1;
    rd_cnt = 0;
    repeat (5) begin
      step();
      rd_cnt += int'(last_rd);
    end
    check("rd_during_full_le1", rd_cnt <= 1, 1);
    mask_out_full = 1'b0;
    step();
    check("wr_on_release", last_wr, 1);
    drain();
    check("frame0_fg_count", fg_count, 5);

    // Frame 1: no foreground; first pixel arrives with the live FIFO empty
    push_quiet();
    tmp = img_q.pop_back();
    refresh();
    repeat (3) step();
    check("starve_no_rd", last_rd, 0);
    img_q.push_back(tmp);
    refresh();
    for (int k = 1; k < FP; k++) push_quiet();
    drain();
    check("frame1_fg_count", fg_count, 0);

    // Frame 2: change threshold and mode at pixel 7; rest of frame keeps 50/MASK
    for (int k = 0; k < 7; k++) push_quiet();
    drain();
    load_thr(8'd200);
    cur_mode = 2'b01;
    mode     = cur_mode;
    for (int k = 7; k < FP; k++) push_px(8'd50, 8'd150);
    // Frame 3: 200/DIFF from pixel 0
    push_px(8'd10, 8'd200);
    for (int k = 1; k < 5; k++) push_quiet();
    drain();
    load_thr(8'd50);
    cur_mode = 2'b10;
    mode     = cur_mode;
    for (int k = 5; k < FP; k++) push_quiet();
    // Frame 4: MASKED
    push_px(8'd10, 8'd200);
    push_px(8'd10, 8'd20);
    drain();

    // Async reset while the output is stalled mid-stream
    for (int k = 0; k < 4; k++) push_quiet();
    repeat (2) step();
    mask_out_full = 1'b1;
    repeat (2) step();
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_base_rd_en", base_rd_en, 0);
    check("mid_rst_img_rd_en", img_in_rd_en, 0);
    check("mid_rst_wr_en", mask_out_wr_en, 0);
    check("mid_rst_din", mask_out_din, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check("mid_rst_fg_count", fg_count, 0);
    base_q.delete();
    img_q.delete();
    exp_q.delete();
    exp_done_next = 1'b0;
    m_idx         = 0;
    m_acc         = '0;
    m_pend        = 8'd50;
    mask_out_full = 1'b0;
    cur_mode      = 2'b11;
    mode          = cur_mode;
    refresh();
    repeat (2) step();
    reset = 1'b1;

    // Fresh frame counted from index 0; mode 11 behaves as MASK
    for (int k = 0; k < FP; k++)
      push_px(PW'($urandom_range(0, 255)), PW'($urandom_range(0, 255)));
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
